muldiv_iter_unit: RTL and testbench

MULDIV_ITER_UNIT -- requirements
Module: muldiv_iter_unit

---
 rtl/muldiv_pkg.sv | 11 +
 rtl/muldiv_step.sv | 21 ++
 rtl/muldiv_iter_unit.sv | 98 +++++++++
 tb/tb_muldiv_iter_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings plus op decode helpers for the iterative multiply/divide unit
package muldiv_pkg;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FIX = 2'b10} state_t;
  function automatic logic is_div(input op_t o);
    return o == OP_DIV || o == OP_DIVU;
  endfunction
  function automatic logic is_signed(input op_t o);
    return o == OP_MULT || o == OP_DIV;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration, shift-add for multiply or restoring shift-subtract for divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH:0] sum, sh, diff;
  assign sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  assign sh   = {acc, q[WIDTH-1]};
  assign diff = sh - {1'b0, m};
  // diff[WIDTH] set means the trial subtract went negative, so the shifted remainder is kept
  always_comb begin
    acc_n = div ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    q_n   = div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative MULT/MULTU/DIV/DIVU over magnitudes with HI/LO result registers
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_wd,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  op_t op_in, op_r;
  logic sa, sb, neg_q, neg_r, zero_r, last;
  logic [WIDTH-1:0] ma, mb, acc, q, m, acc_n, q_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] prod;
  assign op_in = op_t'(op);
  assign sa    = is_signed(op_in) & a[WIDTH-1];
  assign sb    = is_signed(op_in) & b[WIDTH-1];
  assign ma    = sa ? -a : a;
  assign mb    = sb ? -b : b;
  assign last  = cnt == CW'(WIDTH - 1);
  assign prod  = neg_q ? -{acc, q} : {acc, q};
  assign busy  = state != S_IDLE;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div  (is_div(op_r)),
    .acc  (acc),
    .q    (q),
    .m    (m),
    .acc_n(acc_n),
    .q_n  (q_n)
  );
  always_comb begin
    state_n = (state == S_IDLE && start) ? S_RUN :
              (state == S_RUN && last)   ? S_FIX :
              (state == S_FIX)           ? S_IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  // divide keeps the remainder in acc and builds the quotient in q; multiply builds {acc,q}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= OP_MULT;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_r   <= 1'b0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= state == S_FIX;
      div_zero <= state == S_FIX && is_div(op_r) && zero_r;
      if (state == S_IDLE) begin
        if (mthi) hi <= mt_wd;
        if (mtlo) lo <= mt_wd;
        if (start) begin
          op_r   <= op_in;
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          zero_r <= b == '0;
          m      <= is_div(op_in) ? mb : ma;
          q      <= is_div(op_in) ? ma : mb;
          acc    <= '0;
          cnt    <= '0;
        end
      end else if (state == S_RUN) begin
        acc <= acc_n;
        q   <= q_n;
        cnt <= cnt + 1'b1;
      end else if (state == S_FIX) begin
        if (!is_div(op_r)) {hi, lo} <= prod;
        else if (!zero_r) begin
          hi <= neg_r ? -acc : acc;
          lo <= prod[WIDTH-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// tb_muldiv_iter_unit: directed and random checks of muldiv_iter_unit against an arithmetic model
module tb_muldiv_iter_unit;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0, mthi = 0, mtlo = 0;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0, mt_wd = 0;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic start8 = 0;
  logic [1:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic busy8, done8, dz8;
  logic [7:0] hi8, lo8;
  int checks = 0, failures = 0;
  logic [W-1:0] eh = 0, el = 0;

  muldiv_iter_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .mt_wd(mt_wd),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  muldiv_iter_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .mthi(1'b0), .mtlo(1'b0), .mt_wd(8'h00),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // returns {div_zero, hi, lo}; h/l are the HI/LO values before the op
  function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] h, input logic [W-1:0] l);
    longint sx, sy;
    logic [63:0] ux, uy, r, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (o == 2'd0) begin r = sx * sy; return {1'b0, r}; end
    if (o == 2'd1) begin r = ux * uy; return {1'b0, r}; end
    if (y == 0) return {1'b1, h, l};
    if (o == 2'd2) begin qq = sx / sy; rr = sx % sy; end
    else begin qq = ux / uy; rr = ux % uy; end
    return {1'b0, rr[31:0], qq[31:0]};
  endfunction

  // called at a negedge; returns at the negedge of the done cycle
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int inj, input bit mt, input logic [W-1:0] wd, input string tag);
    logic [64:0] e;
    int busy_n, done_at;
    bit moved;
    logic dz_s;
    logic [W-1:0] h0, l0, hs, ls;
    busy_n = 0; done_at = -1; moved = 0;
    start = 1; op = o; a = x; b = y;
    if (mt) begin mthi = 1; mtlo = 1; mt_wd = wd; eh = wd; el = wd; end
    e = model(o, x, y, eh, el);
    @(posedge clk);
    #1 start = 0; mthi = 0; mtlo = 0; a = $urandom; b = $urandom; op = 2'($urandom);
    for (int n = 0; n <= W + 5; n++) begin
      @(negedge clk);
      if (n == 0) begin
        h0 = hi; l0 = lo;
        if (mt) chk({tag, "_mt"}, {hi, lo}, {wd, wd});
      end else if (!done && (hi !== h0 || lo !== l0)) moved = 1;
      if (inj > 0 && n == inj) begin
        start = 1; op = 2'($urandom); a = $urandom; b = $urandom;
        mthi = 1; mtlo = 1; mt_wd = $urandom;
      end
      if (inj > 0 && n == inj + 1) begin start = 0; mthi = 0; mtlo = 0; end
      if (busy) busy_n++;
      if (done) begin done_at = n; dz_s = div_zero; hs = hi; ls = lo; break; end
    end
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
    chk({tag, "_done_at"}, 64'(done_at), 64'(W + 1));
    chk({tag, "_div_zero"}, {63'b0, dz_s}, {63'b0, e[64]});
    chk({tag, "_hi"}, {32'b0, hs}, {32'b0, e[63:32]});
    chk({tag, "_lo"}, {32'b0, ls}, {32'b0, e[31:0]});
    chk({tag, "_hold"}, {63'b0, moved}, 64'b0);
    eh = e[63:32];
    el = e[31:0];
  endtask

  initial begin
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    int busy_n, done_at;
    repeat (2) @(negedge clk);
    chk("reset_flags", {61'b0, busy, done, div_zero}, 64'b0);
    chk("reset_hilo", {hi, lo}, 64'b0);
    rst = 0;
    run_op(2'd0, 32'd7, 32'hFFFFFFFD, -1, 0, 0, "mult_7_m3");
    chk("mult_7_m3_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, 0, "multu_max");
    chk("multu_max_const", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
    run_op(2'd3, 32'd100, 32'd7, -1, 0, 0, "divu_100_7");
    chk("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});
    run_op(2'd2, -32'sd7, 32'd2, -1, 0, 0, "div_m7_2");
    chk("div_m7_2_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, -1, 0, 0, "div_ovf");
    chk("div_ovf_const", {hi, lo}, {32'h0, 32'h80000000});
    mthi = 1; mt_wd = 32'h1234;
    @(posedge clk);
    #1 mthi = 0; mtlo = 1; mt_wd = 32'h5678;
    @(posedge clk);
    #1 mtlo = 0; eh = 32'h1234; el = 32'h5678;
    @(negedge clk);
    chk("mt_write", {hi, lo}, {32'h1234, 32'h5678});
    run_op(2'd2, 32'd5, 32'd0, -1, 0, 0, "div_zero");
    chk("div_zero_const", {hi, lo}, {32'h1234, 32'h5678});
    run_op(2'd1, 32'h0001_0003, 32'h0002_0005, -1, 1, 32'hA5A5_5A5A, "mt_with_start");
    run_op(2'd0, 32'hDEAD_BEEF, 32'h1357_9BDF, 5, 0, 0, "mult_ignore");
    run_op(2'd3, 32'hFFFF_FFF0, 32'd0, -1, 1, 32'hCAFE_F00D, "divu_zero_mt");
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? '0 : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50)) - 32'd25;
      run_op(ro, ra, rb, (i % 4 == 1) ? 3 + i : -1, 0, 0, $sformatf("rnd%0d", i));
    end
    start = 1; op = 2'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_flags", {61'b0, busy, done, div_zero}, 64'b0);
    chk("abort_hilo", {hi, lo}, 64'b0);
    eh = 0; el = 0;
    @(negedge clk);
    rst = 0;
    run_op(2'd3, 32'd1000, 32'd3, -1, 0, 0, "after_reset");
    start8 = 1; op8 = 2'd0; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk);
    #1 start8 = 0;
    busy_n = 0; done_at = -1;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) begin done_at = n; break; end
    end
    chk("w8_busy_cycles", 64'(busy_n), 64'd9);
    chk("w8_done_at", 64'(done_at), 64'd9);
    chk("w8_hilo", {48'b0, hi8, lo8}, {48'b0, 8'h40, 8'h00});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
